// File: rtl/delta_decoder.sv
// rtl/delta_decoder.sv - delta-modulation spike decoder with one-entry valid/ready output register
// Optional build macro DELTA_LEAK_EN: leak recon one LSB toward the seed after LEAK_CYCLES held codes.
module delta_decoder #(
  parameter int DATA_W      = 4,
  parameter int ERR_W       = 8,
  parameter int LEAK_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] threshold,
  input  logic              off_spike,
  input  logic              seed_valid,
  input  logic [DATA_W-1:0] seed_data,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        spike,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              locked
);

  typedef enum logic {SEED, RUN} state_t;

  localparam logic [DATA_W+1:0] MAX_EXT = {2'b00, {DATA_W{1'b1}}};

  state_t            state, next_state;
  logic [DATA_W-1:0] recon, recon_next;
  logic [DATA_W+1:0] step, recon_ext, sum_up, sum_dn;
  logic              accept, seed_load, illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEED;
    else     state <= next_state;
  end

  // clear wins over both seeding and code acceptance
  always_comb begin
    next_state = state;
    case (state)
      SEED:    if (seed_valid && !clear) next_state = RUN;
      RUN:     if (clear) next_state = SEED;
      default: next_state = SEED;
    endcase
  end

  always_comb begin
    locked   = (state == RUN);
    in_ready = (state == RUN) && !clear && (!out_valid || out_ready);
  end

  assign accept    = in_valid && in_ready;
  assign seed_load = (state == SEED) && seed_valid && !clear;
  assign step      = {2'b00, threshold} + {{(DATA_W+1){1'b0}}, 1'b1};
  assign recon_ext = {2'b00, recon};
  assign sum_up    = recon_ext + step;
  assign sum_dn    = recon_ext - step;

`ifdef DELTA_LEAK_EN
  localparam int LEAK_W = $clog2(LEAK_CYCLES) + 1;

  logic [LEAK_W-1:0] leak_cnt;
  logic [DATA_W-1:0] seed_copy;
  logic              leak_hit;

  assign leak_hit = (leak_cnt == LEAK_W'(LEAK_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leak_cnt  <= '0;
      seed_copy <= '0;
    end else begin
      if (seed_load) seed_copy <= seed_data;
      if (clear)
        leak_cnt <= '0;
      else if (accept) begin
        if (spike == 2'b00 && !leak_hit) leak_cnt <= leak_cnt + 1'b1;
        else                             leak_cnt <= '0;
      end
    end
  end
`endif

  // a negative down-step wraps far above MAX_EXT, so one compare catches underflow
  always_comb begin
    recon_next = recon;
    illegal    = 1'b0;
    case (spike)
      2'b01: recon_next = (sum_up > MAX_EXT) ? {DATA_W{1'b1}} : sum_up[DATA_W-1:0];
      2'b11: begin
        if (off_spike) recon_next = (sum_dn > MAX_EXT) ? '0 : sum_dn[DATA_W-1:0];
        else           illegal = 1'b1;
      end
      2'b10: illegal = 1'b1;
      default: begin
`ifdef DELTA_LEAK_EN
        if (leak_hit) begin
          if (recon < seed_copy)      recon_next = recon + 1'b1;
          else if (recon > seed_copy) recon_next = recon - 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      recon     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (seed_load)
        recon <= seed_data;
      else if (accept)
        recon <= recon_next;

      if (accept && illegal && err_cnt != {ERR_W{1'b1}})
        err_cnt <= err_cnt + 1'b1;

      if (clear)
        out_valid <= 1'b0;
      else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= recon_next;
      end else if (out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delta_decoder.sv
// tb/tb_delta_decoder.sv - directed self-checking bench for delta_decoder
module tb_delta_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] threshold;
  logic       off_spike;
  logic       seed_valid;
  logic [3:0] seed_data;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] spike;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [7:0] err_cnt;
  logic       locked;

  int n_checks = 0;
  int n_fail   = 0;

  delta_decoder #(.DATA_W(4), .ERR_W(8), .LEAK_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .threshold(threshold), .off_spike(off_spike),
    .seed_valid(seed_valid), .seed_data(seed_data), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .spike(spike),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_cnt(err_cnt), .locked(locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] code);
    in_valid = 1'b1;
    spike    = code;
    tick();
    in_valid = 1'b0;
    spike    = 2'b00;
  endtask

  task automatic reseed(input logic [3:0] v);
    clear = 1'b1;
    tick();
    clear      = 1'b0;
    seed_valid = 1'b1;
    seed_data  = v;
    tick();
    seed_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; threshold = 4'd0; off_spike = 1'b0; seed_valid = 1'b0;
    seed_data = 4'd0; clear = 1'b0; in_valid = 1'b0; spike = 2'b00; out_ready = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, out_data, err_cnt, locked, in_ready} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b data=%0d err=%0d locked=%0b rdy=%0b, want all 0",
               out_valid, out_data, err_cnt, locked, in_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    threshold = 4'd1; off_spike = 1'b1;
    seed_valid = 1'b1; seed_data = 4'd5;
    tick();
    seed_valid = 1'b0;
    n_checks++;
    if (locked !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_lock: locked=%0b valid=%0b, want 1/0", locked, out_valid);
    end
    send(2'b01);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd7) begin
      n_fail++;
      $display("FAIL up1: valid=%0b data=%0d, want 1/7", out_valid, out_data);
    end
    send(2'b01);
    n_checks++;
    if (out_data !== 4'd9) begin
      n_fail++;
      $display("FAIL up2: data=%0d, want 9", out_data);
    end
    send(2'b11);
    n_checks++;
    if (out_data !== 4'd7) begin
      n_fail++;
      $display("FAIL down1: data=%0d, want 7", out_data);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_saturate();
    threshold = 4'd2;
    reseed(4'd14);
    send(2'b01);
    n_checks++;
    if (out_data !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_high: data=%0d, want 15", out_data);
    end
    reseed(4'd1);
    send(2'b11);
    n_checks++;
    if (out_data !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_low: data=%0d, want 0", out_data);
    end
  endtask

  task automatic test_illegal();
    off_spike = 1'b0;
    reseed(4'd6);
    send(2'b11);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd6) begin
      n_fail++;
      $display("FAIL illegal_11: valid=%0b data=%0d, want 1/6", out_valid, out_data);
    end
    send(2'b10);
    n_checks++;
    if (out_data !== 4'd6 || err_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL illegal_10: data=%0d err=%0d, want 6/2", out_data, err_cnt);
    end
    in_valid = 1'b1;
    spike    = 2'b10;
    for (int i = 0; i < 256; i++) tick();
    in_valid = 1'b0;
    spike    = 2'b00;
    n_checks++;
    if (err_cnt !== 8'd255 || out_data !== 4'd6) begin
      n_fail++;
      $display("FAIL err_saturate: err=%0d data=%0d, want 255/6", err_cnt, out_data);
    end
  endtask

  task automatic test_back_to_back();
    off_spike = 1'b1; threshold = 4'd0;
    reseed(4'd0);
    send(2'b01);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    spike     = 2'b01;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_ready: in_ready=%0b, want 0", in_ready);
    end
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: valid=%0b data=%0d rdy=%0b, want 1/1/0", out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 4'(i)) begin
        n_fail++;
        $display("FAIL resume_%0d: valid=%0b data=%0d, want 1/%0d", i, out_valid, out_data, i);
      end
    end
    in_valid = 1'b0;
    spike    = 2'b00;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 4'd4) begin
      n_fail++;
      $display("FAIL resume_drain: valid=%0b data=%0d, want 0/4", out_valid, out_data);
    end
  endtask

  task automatic test_clear();
    send(2'b01);
    clear    = 1'b1;
    in_valid = 1'b1;
    spike    = 2'b01;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ready: in_ready=%0b, want 0", in_ready);
    end
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    spike    = 2'b00;
    n_checks++;
    if (locked !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_state: locked=%0b valid=%0b, want 0/0", locked, out_valid);
    end
    seed_valid = 1'b1;
    seed_data  = 4'd3;
    tick();
    seed_valid = 1'b0;
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL reseed_lock: locked=%0b, want 1", locked);
    end
    send(2'b00);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd3) begin
      n_fail++;
      $display("FAIL reseed_hold: valid=%0b data=%0d, want 1/3", out_valid, out_data);
    end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1;
    spike    = 2'b01;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, out_data, err_cnt, locked} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%0b data=%0d err=%0d locked=%0b, want all 0",
               out_valid, out_data, err_cnt, locked);
    end
    in_valid = 1'b0;
    spike    = 2'b00;
    tick();
    rst = 1'b0;
    tick();
  endtask

`ifdef DELTA_LEAK_EN
  task automatic test_leak();
    threshold  = 4'd0;
    seed_valid = 1'b1;
    seed_data  = 4'd4;
    tick();
    seed_valid = 1'b0;
    send(2'b01);
    n_checks++;
    if (out_data !== 4'd5) begin
      n_fail++;
      $display("FAIL leak_up: data=%0d, want 5", out_data);
    end
    for (int i = 1; i <= 8; i++) begin
      send(2'b00);
      n_checks++;
      if (out_data !== ((i == 8) ? 4'd4 : 4'd5)) begin
        n_fail++;
        $display("FAIL leak_hold_%0d: data=%0d, want %0d", i, out_data, (i == 8) ? 4 : 5);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_illegal();
    test_back_to_back();
    test_clear();
    test_reset_midstream();
`ifdef DELTA_LEAK_EN
    test_leak();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delta_decoder.md
Name: delta_decoder

Overview:
- Receive side of the delta-modulation spike link: takes per-sample 2-bit spike codes from the delta encoder and rebuilds the 4-bit sample stream.
- Keeps a running reconstruction register, seeded once with the encoder's starting `prev` value.
- Sits downstream of the spike channel; its output feeds the sample consumer through a one-entry valid/ready output register.

Parameters:
- DATA_W, 4, sample and threshold width.
- ERR_W, 8, width of the saturating illegal-code counter.
- LEAK_CYCLES, 8, consecutive no-spike samples before one leak step (used only with DELTA_LEAK_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- threshold  in  DATA_W  encoder threshold; step = threshold + 1.
- off_spike  in  1  encoder down-spikes enabled.
- seed_valid  in  1  load seed_data into reconstruction.
- seed_data  in  DATA_W  initial reconstruction value.
- clear  in  1  synchronous return to SEED state.
- in_valid  in  1  spike code present.
- in_ready  out  1  decoder accepts code this cycle.
- spike  in  2  bit0 = event, bit1 = down polarity.
- out_valid  out  1  reconstructed sample available.
- out_ready  in  1  consumer takes sample.
- out_data  out  DATA_W  reconstructed sample.
- err_cnt  out  ERR_W  count of illegal codes, saturating.
- locked  out  1  high in RUN state.

Behaviour:
- Reset (async): state=SEED, recon=0, out_data=0, out_valid=0, err_cnt=0, locked=0, leak counter=0.
- States:
  - SEED: in_ready=0. seed_valid=1 -> recon=seed_data, next state RUN. Output register unchanged.
  - RUN: locked=1. clear=1 -> SEED, out_valid=0, leak counter=0; recon and err_cnt hold. clear has priority over in_valid and over seed_valid.
  - seed_valid in RUN is ignored.
- Handshake: in_ready = RUN && !clear && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Code decode on accept:
  - 00 = hold.
  - 01 = up: recon + step.
  - 11 = down: recon - step, legal only if off_spike=1.
  - 10 = illegal.
  - 11 with off_spike=0 = illegal.
  - Illegal codes: recon holds; err_cnt += 1, saturating at all-ones. A sample is still emitted.
- Arithmetic: step and sums use DATA_W+2 bits. Results saturate to 0..2^DATA_W-1; no wrap.
- Latency: the accepted code in cycle N gives out_data/out_valid in cycle N+1. out_data equals the new recon.
- Output register: out_valid clears on out_ready unless a new accept happens in the same cycle, in which case it reloads and stays high. out_data holds stable while out_valid && !out_ready.
- Back-to-back accepts are sustained at 1 per cycle when out_ready=1.
- threshold and off_spike are sampled at accept time; changes mid-stream take effect on the next accept.
- Reset during RUN: immediate return to the reset values above, including out_valid=0.

Optional Feature:
- Macro: DELTA_LEAK_EN.
- Defined:
  - An internal counter tracks consecutive accepted 00 codes; any other accepted code, or clear, zeroes it.
  - When it reaches LEAK_CYCLES, that accept moves recon one LSB toward seed_data latched at seed time; if already equal, recon holds. The counter then restarts at 0.
  - The emitted sample includes the leak.
- Not defined: no leak counter or latched seed copy is built; 00 always holds recon.

Test Plan:
- Reset, seed_data=5, threshold=1, off_spike=1; codes 01,01,11 with out_ready=1 -> out_data 7,9,7, each one cycle after accept.
- Seed 14, threshold=2, code 01 -> out_data=15 (saturates). Seed 1, code 11 -> out_data=0.
- off_spike=0, seed 6, codes 11 then 10 -> out_data 6,6; err_cnt=2. Then 256 illegal codes with ERR_W=8 -> err_cnt stays 255.
- out_ready=0 after first sample -> in_ready=0, out_data holds; raise out_ready with in_valid high -> one sample per cycle resumes, nothing dropped or duplicated.
- In RUN, assert clear with in_valid=1 -> code not accepted, locked=0, out_valid=0. Then seed_valid with seed_data=3 -> locked=1, next code 00 -> out_data=3. Assert rst mid-stream -> all outputs 0 immediately.
- DELTA_LEAK_EN, LEAK_CYCLES=8, seed 4, code 01 (threshold=0) -> 5; then 8 codes 00 -> eighth output 4, first seven output 5.
